// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined RV32I control path:
// opcodes, ALU codes, mux selects and stage bundles.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic       valid;
    logic       ill;
    logic       reg_write;
    logic       mem_write;
    res_src_e   result_src;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] funct3;
    logic       alu_src_a;
    logic       alu_src_b;
    alu_op_e    alu_control;
  } ctrl_bundle_t;

  typedef struct packed {
    logic     valid;
    logic     ill;
    logic     reg_write;
    logic     mem_write;
    res_src_e result_src;
  } mem_bundle_t;

  // funct3[0] inverts the base condition (BNE/BGE/BGEU)
  function automatic logic br_taken(
    input logic [2:0] f3,
    input logic       zero,
    input logic       lt,
    input logic       ltu
  );
    logic c;
    case (f3[2:1])
      2'b00:   c = zero;
      2'b10:   c = lt;
      2'b11:   c = ltu;
      default: c = 1'b0;
    endcase
    return (f3[2:1] == 2'b01) ? 1'b0 : (c ^ f3[0]);
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Decode-stage main and ALU decoder.
// Produces the Execute-bound control bundle and the illegal flag.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter bit FULL_BRANCH = 1'b1
) (
  input  logic [6:0]   op_i,
  input  logic [2:0]   funct3_i,
  input  logic         funct7b5_i,
  output ctrl_bundle_t ctrl_o,
  output logic [2:0]   imm_src_o,
  output logic         illegal_o
);

  logic         is_r;
  alu_op_e      alu_arith;
  logic         arith_ok;
  logic         br_ok;
  logic         ld_ok;
  logic         st_ok;
  logic         ok;
  ctrl_bundle_t ctrl;
  imm_src_e     imm;

  assign is_r  = (op_i == OP_R);
  assign br_ok = (funct3_i[2:1] == 2'b00) ||
                 (funct3_i[2] && FULL_BRANCH);
  assign ld_ok = funct3_i inside
                 {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign st_ok = funct3_i inside {3'b000, 3'b001, 3'b010};

  // shared R / I-ALU operation select
  always_comb begin
    alu_arith = ALU_ADD;
    arith_ok  = 1'b1;
    case (funct3_i)
      3'b000: alu_arith = (is_r && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        alu_arith = ALU_SLL;
        arith_ok  = !funct7b5_i;
      end
      3'b010: begin
        alu_arith = ALU_SLT;
        arith_ok  = !(is_r && funct7b5_i);
      end
      3'b011: begin
        alu_arith = ALU_SLTU;
        arith_ok  = !(is_r && funct7b5_i);
      end
      3'b100: begin
        alu_arith = ALU_XOR;
        arith_ok  = !(is_r && funct7b5_i);
      end
      3'b101: alu_arith = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110: begin
        alu_arith = ALU_OR;
        arith_ok  = !(is_r && funct7b5_i);
      end
      default: begin
        alu_arith = ALU_AND;
        arith_ok  = !(is_r && funct7b5_i);
      end
    endcase
  end

  always_comb begin
    ctrl             = '0;
    ctrl.valid       = 1'b1;
    ctrl.funct3      = funct3_i;
    ctrl.alu_control = ALU_ADD;
    imm              = IMM_I;
    ok               = 1'b1;
    unique case (1'b1)
      (op_i == OP_R): begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_arith;
        ok               = arith_ok;
      end
      (op_i == OP_IMM): begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_b   = 1'b1;
        ctrl.alu_control = alu_arith;
        ok               = arith_ok;
      end
      (op_i == OP_LOAD): begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src_b  = 1'b1;
        ok              = ld_ok;
      end
      (op_i == OP_STORE): begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm            = IMM_S;
        ok             = st_ok;
      end
      (op_i == OP_BRANCH): begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm              = IMM_B;
        ok               = br_ok;
      end
      (op_i == OP_JAL): begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        imm             = IMM_J;
      end
      (op_i == OP_JALR): begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jalr       = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ok              = (funct3_i == 3'b000);
      end
      (op_i == OP_LUI): begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_IMM;
        imm             = IMM_U;
      end
      (op_i == OP_AUIPC): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm            = IMM_U;
      end
      default: ok = 1'b0;
    endcase
    // an unrecognised instruction travels as a side-effect-free marker
    if (!ok) begin
      ctrl       = '0;
      ctrl.valid = 1'b1;
      ctrl.ill   = 1'b1;
      imm        = IMM_I;
    end
  end

  assign ctrl_o    = ctrl;
  assign imm_src_o = imm;
  assign illegal_o = !ok;

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control path: decode, E/M/W control registers,
// branch resolution, sticky illegal trap and retire counter.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter bit FULL_BRANCH = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op_d,
  input  logic [2:0]            funct3_d,
  input  logic                  funct7b5_d,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [2:0]            imm_src_d,
  output logic                  illegal_d,
  output logic                  alu_src_a_e,
  output logic                  alu_src_b_e,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic [1:0]            result_src_e,
  output logic                  reg_write_e,
  output logic                  reg_write_m,
  output logic                  reg_write_w,
  output logic                  mem_write_m,
  output logic [1:0]            result_src_w,
  output logic [1:0]            pcsrc_e,
  output logic                  trap,
  output logic [CNT_W-1:0]      instret
);

  ctrl_bundle_t dec_b;
  ctrl_bundle_t e_d, e_q;
  mem_bundle_t  m_d, m_q;
  logic         valid_w_q, ill_w_q, reg_write_w_q;
  res_src_e     result_src_w_q;
  logic         trap_d, trap_q;
  logic [CNT_W-1:0] instret_d, instret_q;
  pc_src_e      pcsrc;
  logic         ret_w;

  pipe_ctrl_decode #(
    .FULL_BRANCH(FULL_BRANCH)
  ) u_decode (
    .op_i      (op_d),
    .funct3_i  (funct3_d),
    .funct7b5_i(funct7b5_d),
    .ctrl_o    (dec_b),
    .imm_src_o (imm_src_d),
    .illegal_o (illegal_d)
  );

  assign e_d = flush_e ? '0 : dec_b;

  always_comb begin
    m_d            = '0;
    m_d.valid      = e_q.valid;
    m_d.ill        = e_q.ill;
    m_d.reg_write  = e_q.reg_write;
    m_d.mem_write  = e_q.mem_write;
    m_d.result_src = e_q.result_src;
  end

  always_comb begin
    pcsrc = PC_PLUS4;
    unique case (1'b1)
      (e_q.valid && e_q.jalr): pcsrc = PC_ALU;
      (e_q.valid && (e_q.jump || (e_q.branch &&
        br_taken(e_q.funct3, zero_e, lt_e, ltu_e)))):
        pcsrc = PC_IMM;
      default: pcsrc = PC_PLUS4;
    endcase
  end

  assign ret_w     = valid_w_q && !ill_w_q;
  assign trap_d    = trap_q || (e_q.valid && e_q.ill);
  assign instret_d = instret_q + CNT_W'(ret_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q            <= '0;
      m_q            <= '0;
      valid_w_q      <= 1'b0;
      ill_w_q        <= 1'b0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= RES_ALU;
      trap_q         <= 1'b0;
      instret_q      <= '0;
    end else begin
      e_q            <= e_d;
      m_q            <= m_d;
      valid_w_q      <= m_q.valid;
      ill_w_q        <= m_q.ill;
      reg_write_w_q  <= m_q.reg_write;
      result_src_w_q <= m_q.result_src;
      trap_q         <= trap_d;
      instret_q      <= instret_d;
    end
  end

  assign alu_src_a_e   = e_q.alu_src_a;
  assign alu_src_b_e   = e_q.alu_src_b;
  assign alu_control_e = ALU_CTRL_W'(e_q.alu_control);
  assign result_src_e  = e_q.result_src;
  assign reg_write_e   = e_q.reg_write;
  assign reg_write_m   = m_q.reg_write;
  assign mem_write_m   = m_q.mem_write;
  assign reg_write_w   = reg_write_w_q;
  assign result_src_w  = result_src_w_q;
  assign pcsrc_e       = pcsrc;
  assign trap          = trap_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: full-branch 32-bit instance
// alongside a BEQ/BNE-only instance with a 4-bit retire counter.
module tb_pipe_controller;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] JL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP = 7'b1100111;

  logic clk, rst_n;
  logic [6:0] op_d;
  logic [2:0] funct3_d;
  logic funct7b5_d, flush_e, zero_e, lt_e, ltu_e;

  logic [2:0] imm_src_d, imm_src_d4;
  logic illegal_d, illegal_d4;
  logic asa, asa4, asb, asb4;
  logic [3:0] alu_c, alu_c4;
  logic [1:0] rs_e, rs_e4, rs_w, rs_w4, pcs, pcs4;
  logic rw_e, rw_e4, rw_m, rw_m4, rw_w, rw_w4, mw_m, mw_m4;
  logic trap, trap4;
  logic [31:0] instret;
  logic [3:0] instret4;

  int n_checks = 0;
  int n_fail = 0;
  int ret = 0;
  int ret4 = 0;

  pipe_controller #(
    .ALU_CTRL_W(4), .FULL_BRANCH(1'b1), .CNT_W(32)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .funct3_d(funct3_d),
    .funct7b5_d(funct7b5_d), .flush_e(flush_e), .zero_e(zero_e),
    .lt_e(lt_e), .ltu_e(ltu_e), .imm_src_d(imm_src_d),
    .illegal_d(illegal_d), .alu_src_a_e(asa), .alu_src_b_e(asb),
    .alu_control_e(alu_c), .result_src_e(rs_e),
    .reg_write_e(rw_e), .reg_write_m(rw_m), .reg_write_w(rw_w),
    .mem_write_m(mw_m), .result_src_w(rs_w), .pcsrc_e(pcs),
    .trap(trap), .instret(instret)
  );

  pipe_controller #(
    .ALU_CTRL_W(4), .FULL_BRANCH(1'b0), .CNT_W(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .funct3_d(funct3_d),
    .funct7b5_d(funct7b5_d), .flush_e(flush_e), .zero_e(zero_e),
    .lt_e(lt_e), .ltu_e(ltu_e), .imm_src_d(imm_src_d4),
    .illegal_d(illegal_d4), .alu_src_a_e(asa4), .alu_src_b_e(asb4),
    .alu_control_e(alu_c4), .result_src_e(rs_e4),
    .reg_write_e(rw_e4), .reg_write_m(rw_m4), .reg_write_w(rw_w4),
    .mem_write_m(mw_m4), .result_src_w(rs_w4), .pcsrc_e(pcs4),
    .trap(trap4), .instret(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic fl);
    op_d       = op;
    funct3_d   = f3;
    funct7b5_d = f7;
    flush_e    = fl;
  endtask

  task automatic idle(input int n);
    flush_e = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    zero_e = 1'b0;
    lt_e = 1'b0;
    ltu_e = 1'b0;
    drive(I_OP, 3'b000, 1'b0, 1'b1);
    repeat (3) tick();
    check("rst_rw_e", 32'(rw_e), 0);
    check("rst_rw_m", 32'(rw_m), 0);
    check("rst_rw_w", 32'(rw_w), 0);
    check("rst_mw_m", 32'(mw_m), 0);
    check("rst_pcsrc", 32'(pcs), 0);
    check("rst_rs_e", 32'(rs_e), 0);
    check("rst_rs_w", 32'(rs_w), 0);
    check("rst_alu", 32'(alu_c), 0);
    check("rst_trap", 32'(trap), 0);
    check("rst_instret", instret, 0);
    rst_n = 1'b1;

    // ADD through the pipe
    drive(R_OP, 3'b000, 1'b0, 1'b0);
    #1;
    check("add_ill", 32'(illegal_d), 0);
    tick();
    flush_e = 1'b1;
    check("add_rw_e", 32'(rw_e), 1);
    check("add_alu", 32'(alu_c), 0);
    tick();
    check("add_rw_m", 32'(rw_m), 1);
    tick();
    check("add_rw_w", 32'(rw_w), 1);
    check("add_rs_w", 32'(rs_w), 0);
    check("add_ret_early", instret, 0);
    tick();
    check("add_ret", instret, 1);
    ret = 1;
    ret4 = 1;

    // ALU decode variants
    drive(R_OP, 3'b000, 1'b1, 1'b0);
    tick();
    check("sub_alu", 32'(alu_c), 1);
    check("sub_srcb", 32'(asb), 0);
    drive(I_OP, 3'b101, 1'b1, 1'b0);
    tick();
    check("srai_alu", 32'(alu_c), 9);
    check("srai_srcb", 32'(asb), 1);
    drive(I_OP, 3'b000, 1'b1, 1'b0);
    tick();
    check("addi_f7_alu", 32'(alu_c), 0);
    ret += 3;
    ret4 += 3;
    drive(R_OP, 3'b001, 1'b1, 1'b1);
    #1;
    check("sll_f7_ill", 32'(illegal_d), 1);

    // BLT, legal only on the full-branch instance
    drive(BR_OP, 3'b100, 1'b0, 1'b0);
    #1;
    check("blt_ill", 32'(illegal_d), 0);
    check("blt_ill4", 32'(illegal_d4), 1);
    check("blt_imm", 32'(imm_src_d), 2);
    tick();
    flush_e = 1'b1;
    lt_e = 1'b1;
    #1;
    check("blt_taken", 32'(pcs), 1);
    check("blt_taken4", 32'(pcs4), 0);
    check("blt_alu", 32'(alu_c), 1);
    lt_e = 1'b0;
    #1;
    check("blt_not", 32'(pcs), 0);
    ret += 1;
    tick();
    check("blt_trap4", 32'(trap4), 1);
    check("blt_trap", 32'(trap), 0);

    drive(BR_OP, 3'b001, 1'b0, 1'b0);
    tick();
    flush_e = 1'b1;
    zero_e = 1'b1;
    #1;
    check("bne_eq", 32'(pcs), 0);
    zero_e = 1'b0;
    #1;
    check("bne_ne", 32'(pcs), 1);
    check("bne_ne4", 32'(pcs4), 1);
    ret += 1;
    ret4 += 1;

    drive(BR_OP, 3'b111, 1'b0, 1'b0);
    tick();
    flush_e = 1'b1;
    ltu_e = 1'b0;
    #1;
    check("bgeu_taken", 32'(pcs), 1);
    ltu_e = 1'b1;
    #1;
    check("bgeu_not", 32'(pcs), 0);
    ltu_e = 1'b0;
    ret += 1;

    drive(JL_OP, 3'b000, 1'b0, 1'b0);
    tick();
    flush_e = 1'b1;
    check("jal_pcsrc", 32'(pcs), 1);
    ret += 1;
    ret4 += 1;

    drive(JR_OP, 3'b000, 1'b0, 1'b0);
    tick();
    flush_e = 1'b1;
    check("jalr_pcsrc", 32'(pcs), 2);
    check("jalr_alu", 32'(alu_c), 0);
    check("jalr_srcb", 32'(asb), 1);
    tick();
    tick();
    check("jalr_rs_w", 32'(rs_w), 2);
    ret += 1;
    ret4 += 1;

    // flushed store must never write
    drive(ST_OP, 3'b010, 1'b0, 1'b1);
    #1;
    check("sw_imm", 32'(imm_src_d), 1);
    check("sw_ill", 32'(illegal_d), 0);
    tick();
    tick();
    check("sw_flush_mw", 32'(mw_m), 0);
    drive(ST_OP, 3'b010, 1'b0, 1'b0);
    tick();
    flush_e = 1'b1;
    tick();
    check("sw_mw", 32'(mw_m), 1);
    check("sw_rw_m", 32'(rw_m), 0);
    ret += 1;
    ret4 += 1;
    idle(3);
    check("cnt_mid", instret, 32'(ret));
    check("cnt_mid4", 32'(instret4), 32'(ret4 % 16));

    // illegal opcode: flushed first, then real
    drive(7'b0000000, 3'b000, 1'b0, 1'b1);
    #1;
    check("op0_ill", 32'(illegal_d), 1);
    tick();
    tick();
    check("op0_flush_trap", 32'(trap), 0);
    drive(7'b0000000, 3'b000, 1'b0, 1'b0);
    tick();
    flush_e = 1'b1;
    check("op0_trap_in_e", 32'(trap), 0);
    check("op0_rw_e", 32'(rw_e), 0);
    check("op0_pcsrc", 32'(pcs), 0);
    tick();
    check("op0_trap", 32'(trap), 1);
    for (int i = 0; i < 10; i++) begin
      drive(I_OP, 3'b000, 1'b0, 1'b0);
      tick();
    end
    ret += 10;
    ret4 += 10;
    idle(4);
    check("op0_trap_sticky", 32'(trap), 1);
    check("cnt_after_ill", instret, 32'(ret));
    check("cnt_after_ill4", 32'(instret4), 32'(ret4 % 16));

    // reset while an ADD is in flight
    drive(R_OP, 3'b000, 1'b0, 1'b0);
    tick();
    flush_e = 1'b1;
    check("mid_rw_e", 32'(rw_e), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rw_e", 32'(rw_e), 0);
    check("mid_rst_trap", 32'(trap), 0);
    check("mid_rst_cnt", instret, 0);
    tick();
    tick();
    rst_n = 1'b1;
    idle(3);
    check("mid_rw_w", 32'(rw_w), 0);
    check("mid_cnt", instret, 0);

    // 4-bit counter wraps after 16 retirements
    for (int i = 0; i < 15; i++) begin
      drive(I_OP, 3'b000, 1'b0, 1'b0);
      tick();
    end
    idle(4);
    check("wrap_full4", 32'(instret4), 15);
    check("wrap_full", instret, 15);
    drive(I_OP, 3'b000, 1'b0, 1'b0);
    tick();
    idle(4);
    check("wrap_zero4", 32'(instret4), 0);
    check("wrap_16", instret, 16);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
